// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single SRAM port.
interface mem_arbiter_if;
    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [15:0] wdata0;
    logic        ack0;
    logic [15:0] rdata0;

    logic        req1;
    logic        we1;
    logic [15:0] addr1;
    logic [15:0] wdata1;
    logic        ack1;
    logic [15:0] rdata1;

    logic [15:0] address;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        wren_n;
    logic        oen_n;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  data_in,
        output ack0, rdata0, ack1, rdata1,
        output address, data_out, wren_n, oen_n
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output data_in,
        input  ack0, rdata0, ack1, rdata1,
        input  address, data_out, wren_n, oen_n
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one asynchronous SRAM port, one transaction at a time.
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StTurn} state_e;

    localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);

    state_e     state_q;
    logic [3:0] counter_q;
    logic       grant_q;
    logic       last_grant_q;
    logic       we_q;

    logic pick;
    logic pick_we;

    // On a tie the port that was not served last wins.
    always_comb begin
        pick    = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
        pick_we = pick ? bus.we1 : bus.we0;
    end

    // address/data_out double as the latched request, so SRAM pins come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            counter_q    <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            bus.address  <= '0;
            bus.data_out <= '0;
            bus.wren_n   <= 1'b1;
            bus.oen_n    <= 1'b1;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.rdata0   <= '0;
            bus.rdata1   <= '0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    bus.wren_n <= 1'b1;
                    bus.oen_n  <= 1'b1;
                    if (bus.req0 || bus.req1) begin
                        grant_q      <= pick;
                        we_q         <= pick_we;
                        bus.address  <= pick ? bus.addr1 : bus.addr0;
                        bus.data_out <= pick ? bus.wdata1 : bus.wdata0;
                        bus.wren_n   <= ~pick_we;
                        bus.oen_n    <= pick_we;
                        counter_q    <= WaitCnt;
                        state_q      <= StAccess;
                    end
                end
                StAccess: begin
                    if (counter_q == 4'd0) begin
                        bus.wren_n <= 1'b1;
                        bus.oen_n  <= 1'b1;
                        if (!we_q) begin
                            if (grant_q) bus.rdata1 <= bus.data_in;
                            else         bus.rdata0 <= bus.data_in;
                        end
                        bus.ack0 <= ~grant_q;
                        bus.ack1 <= grant_q;
                        state_q  <= StTurn;
                    end else begin
                        counter_q <= counter_q - 4'd1;
                    end
                end
                StTurn: begin
                    last_grant_q <= grant_q;
                    state_q      <= StIdle;
                end
                default: begin
                    bus.wren_n <= 1'b1;
                    bus.oen_n  <= 1'b1;
                    state_q    <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Drives three arbiters (WAIT_STATES 0, 1, 15) with directed then random traffic and
// compares every cycle against a transaction-level model; literal checks pin the WS=1 copy.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit directed = 1'b1;

    logic        d_req0 = 1'b0, d_we0 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
    logic [15:0] d_addr0 = '0, d_wdata0 = '0, d_addr1 = '0, d_wdata1 = '0, d_data_in = '0;

    logic        obs_wren [3];
    logic        obs_oen  [3];
    logic        obs_ack0 [3];
    logic        obs_ack1 [3];
    logic [15:0] obs_addr [3];
    logic [15:0] obs_dout [3];
    logic [15:0] obs_rd0  [3];
    logic [15:0] obs_rd1  [3];

    int ack_port [8];
    int ack_cyc  [8];
    int n_got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : gen_ws
        localparam int WS = (gi == 0) ? 0 : (gi == 1) ? 1 : 15;

        mem_arbiter_if bus ();
        mem_arbiter #(.WAIT_STATES(WS)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign obs_wren[gi] = bus.wren_n;
        assign obs_oen[gi]  = bus.oen_n;
        assign obs_ack0[gi] = bus.ack0;
        assign obs_ack1[gi] = bus.ack1;
        assign obs_addr[gi] = bus.address;
        assign obs_dout[gi] = bus.data_out;
        assign obs_rd0[gi]  = bus.rdata0;
        assign obs_rd1[gi]  = bus.rdata1;

        bit seen0 = 1'b0, seen1 = 1'b0, pend0 = 1'b0, pend1 = 1'b0;

        // Requesters: copy directed values, or hold a random request until its ack is seen.
        initial begin
            bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
            bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
            bus.data_in = '0;
            forever begin
                @(posedge clk);
                #2;
                if (directed) begin
                    bus.req0 = d_req0; bus.we0 = d_we0; bus.addr0 = d_addr0; bus.wdata0 = d_wdata0;
                    bus.req1 = d_req1; bus.we1 = d_we1; bus.addr1 = d_addr1; bus.wdata1 = d_wdata1;
                    bus.data_in = d_data_in;
                end else begin
                    if (seen0) pend0 = 1'b0;
                    if (seen1) pend1 = 1'b0;
                    if (!pend0 && $urandom_range(0, 2) == 0) begin
                        pend0 = 1'b1;
                        bus.we0 = 1'($urandom_range(0, 1));
                        bus.addr0 = 16'($urandom);
                        bus.wdata0 = 16'($urandom);
                    end
                    if (!pend1 && $urandom_range(0, 2) == 0) begin
                        pend1 = 1'b1;
                        bus.we1 = 1'($urandom_range(0, 1));
                        bus.addr1 = 16'($urandom);
                        bus.wdata1 = 16'($urandom);
                    end
                    bus.req0 = pend0;
                    bus.req1 = pend1;
                    bus.data_in = 16'($urandom);
                end
            end
        end

        // Model: one in-flight transaction, age 1..WS+1 is the access, WS+2 the ack cycle.
        bit          m_valid = 1'b0, m_busy = 1'b0, m_last = 1'b1, m_port = 1'b0, m_we = 1'b0;
        int          m_age = 0;
        logic [15:0] m_addr = '0, m_wdata = '0, m_rd0 = '0, m_rd1 = '0;
        bit          acc, turn;

        initial forever begin
            @(negedge clk);
            seen0 = bus.ack0;
            seen1 = bus.ack1;
            if (m_valid) begin
                acc  = m_busy && (m_age <= WS + 1);
                turn = m_busy && (m_age == WS + 2);
                chk($sformatf("ws%0d_wren_n", WS), bus.wren_n, !(acc && m_we));
                chk($sformatf("ws%0d_oen_n", WS), bus.oen_n, !(acc && !m_we));
                chk($sformatf("ws%0d_ack0", WS), bus.ack0, turn && !m_port);
                chk($sformatf("ws%0d_ack1", WS), bus.ack1, turn && m_port);
                chk($sformatf("ws%0d_rdata0", WS), bus.rdata0, m_rd0);
                chk($sformatf("ws%0d_rdata1", WS), bus.rdata1, m_rd1);
                chk($sformatf("ws%0d_en_excl", WS), bus.wren_n | bus.oen_n, 1);
                chk($sformatf("ws%0d_ack_excl", WS), bus.ack0 & bus.ack1, 0);
                if (acc) chk($sformatf("ws%0d_address", WS), bus.address, m_addr);
                if (acc && m_we) chk($sformatf("ws%0d_data_out", WS), bus.data_out, m_wdata);
            end
            if (rst) begin
                m_busy = 1'b0; m_last = 1'b1; m_rd0 = '0; m_rd1 = '0; m_valid = 1'b1;
            end else if (m_valid) begin
                if (m_busy) begin
                    if (m_age == WS + 1 && !m_we) begin
                        if (m_port) m_rd1 = bus.data_in;
                        else        m_rd0 = bus.data_in;
                    end
                    if (m_age == WS + 2) begin
                        m_busy = 1'b0;
                        m_last = m_port;
                    end else begin
                        m_age++;
                    end
                end else if (bus.req0 || bus.req1) begin
                    m_port  = (bus.req0 && bus.req1) ? ~m_last : bus.req1;
                    m_we    = m_port ? bus.we1 : bus.we0;
                    m_addr  = m_port ? bus.addr1 : bus.addr0;
                    m_wdata = m_port ? bus.wdata1 : bus.wdata0;
                    m_busy  = 1'b1;
                    m_age   = 1;
                end
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Records ack order/cycle on the WS=1 copy; without hold a port drops req after its ack.
    task automatic run_acks(input int n, input bit hold);
        int   cyc = 0;
        logic a0, a1;
        n_got = 0;
        while (n_got < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            a0 = obs_ack0[1];
            a1 = obs_ack1[1];
            if (a0 && n_got < 8) begin ack_port[n_got] = 0; ack_cyc[n_got] = cyc; n_got++; end
            if (a1 && n_got < 8) begin ack_port[n_got] = 1; ack_cyc[n_got] = cyc; n_got++; end
            @(posedge clk);
            #1;
            if (!hold) begin
                if (a0) d_req0 = 1'b0;
                if (a1) d_req1 = 1'b0;
            end
        end
        chk("acks_seen", n_got, n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wren_n", obs_wren[1], 1);
        chk("rst_oen_n", obs_oen[1], 1);
        chk("rst_ack0", obs_ack0[1], 0);
        chk("rst_ack1", obs_ack1[1], 0);
        chk("rst_rdata0", obs_rd0[1], 0);
        chk("rst_rdata1", obs_rd1[1], 0);
        chk("rst_address", obs_addr[1], 0);
        chk("rst_data_out", obs_dout[1], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        gap(2);

        // Single read on port 0
        d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 16'h0010; d_data_in = 16'hBEEF;
        @(negedge clk);
        chk("rd_idle_oen_n", obs_oen[1], 1);
        repeat (2) begin
            @(negedge clk);
            chk("rd_acc_oen_n", obs_oen[1], 0);
            chk("rd_acc_wren_n", obs_wren[1], 1);
            chk("rd_acc_address", obs_addr[1], 16'h0010);
        end
        @(negedge clk);
        chk("rd_ack0", obs_ack0[1], 1);
        chk("rd_ack1", obs_ack1[1], 0);
        chk("rd_rdata0", obs_rd0[1], 16'hBEEF);
        chk("rd_turn_oen_n", obs_oen[1], 1);
        @(posedge clk);
        #1;
        d_req0 = 1'b0;
        @(negedge clk);
        chk("rd_ack0_low", obs_ack0[1], 0);
        chk("rd_rdata0_hold", obs_rd0[1], 16'hBEEF);
        gap(20);

        // Single write on port 1
        d_req1 = 1'b1; d_we1 = 1'b1; d_addr1 = 16'h1234; d_wdata1 = 16'hA5A5;
        @(negedge clk);
        chk("wr_idle_wren_n", obs_wren[1], 1);
        repeat (2) begin
            @(negedge clk);
            chk("wr_acc_wren_n", obs_wren[1], 0);
            chk("wr_acc_oen_n", obs_oen[1], 1);
            chk("wr_acc_data_out", obs_dout[1], 16'hA5A5);
            chk("wr_acc_address", obs_addr[1], 16'h1234);
        end
        @(negedge clk);
        chk("wr_ack1", obs_ack1[1], 1);
        chk("wr_ack0", obs_ack0[1], 0);
        chk("wr_turn_wren_n", obs_wren[1], 1);
        chk("wr_rdata1_kept", obs_rd1[1], 0);
        chk("wr_rdata0_kept", obs_rd0[1], 16'hBEEF);
        @(posedge clk);
        #1;
        d_req1 = 1'b0;
        @(negedge clk);
        chk("wr_ack1_low", obs_ack1[1], 0);
        gap(20);

        // Tie straight after reset: port 0 first
        do_reset();
        d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 16'h0100;
        d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 16'h0200;
        run_acks(2, 1'b0);
        chk("tie_first_port", ack_port[0], 0);
        chk("tie_second_port", ack_port[1], 1);
        chk("tie_first_cycle", ack_cyc[0], 4);
        chk("tie_second_cycle", ack_cyc[1], 8);
        gap(20);

        // Saturation: strict alternation, one ack every WS+3 cycles
        do_reset();
        d_req0 = 1'b1; d_req1 = 1'b1;
        run_acks(6, 1'b1);
        d_req0 = 1'b0; d_req1 = 1'b0;
        for (int i = 0; i < 6; i++) chk($sformatf("sat_port%0d", i), ack_port[i], i % 2);
        for (int i = 1; i < 6; i++) chk($sformatf("sat_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);
        gap(20);

        // Reset during the second access cycle of a write
        d_req0 = 1'b1; d_we0 = 1'b1; d_addr0 = 16'h4000; d_wdata0 = 16'h5A5A;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_acc1_wren_n", obs_wren[1], 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_acc2_wren_n", obs_wren[1], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        d_req0 = 1'b0;
        @(negedge clk);
        chk("rstw_wren_n", obs_wren[1], 1);
        chk("rstw_oen_n", obs_oen[1], 1);
        chk("rstw_ack0", obs_ack0[1], 0);
        chk("rstw_ack1", obs_ack1[1], 0);
        chk("rstw_address", obs_addr[1], 0);
        @(negedge clk);
        chk("rstw_no_late_ack", obs_ack0[1], 0);
        gap(20);

        // Random traffic with rare reset pulses
        directed = 1'b0;
        repeat (4000) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        gap(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
